// File: rtl/nn_stream_adapter.sv
// Stream adapter for the layer-multiplexed network: deserialises samples into the start vector,
// waits for masked completion, then serialises selected result lanes. Optional watchdog: NN_WATCHDOG_EN.
module nn_stream_adapter #(
  parameter int unsigned NUM_NEURON = 6,
  parameter int unsigned INPUT_SIZE = 9,
  parameter logic [NUM_NEURON-1:0] OUTPUT_MASK = {NUM_NEURON{1'b1}},
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [INPUT_SIZE-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             nn_start,
  output logic [NUM_NEURON*INPUT_SIZE-1:0] nn_input,
  input  logic [NUM_NEURON*INPUT_SIZE-1:0] nn_output,
  input  logic [NUM_NEURON-1:0]            nn_output_valid,
  output logic [INPUT_SIZE-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy,
  output logic                             error
);

  localparam int unsigned VEC_W = NUM_NEURON * INPUT_SIZE;
  localparam int unsigned IDX_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;

  // An empty mask would never complete; a watchdog shorter than two cycles cannot cover GUARD.
  if (OUTPUT_MASK == '0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("nn_stream_adapter: OUTPUT_MASK must be non-zero and TIMEOUT_CYCLES >= 2");
  end

  function automatic int unsigned mask_first(input logic [NUM_NEURON-1:0] m);
    int unsigned r;
    r = 0;
    for (int i = int'(NUM_NEURON) - 1; i >= 0; i--) begin
      if (m[i]) r = unsigned'(i);
    end
    return r;
  endfunction

  function automatic int unsigned mask_last(input logic [NUM_NEURON-1:0] m);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < NUM_NEURON; i++) begin
      if (m[i]) r = i;
    end
    return r;
  endfunction

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(mask_first(OUTPUT_MASK));
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(mask_last(OUTPUT_MASK));

  // Next streamed lane above cur; only called while cur is below LAST_IDX.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur);
    logic [IDX_W-1:0] r;
    logic             found;
    r     = cur;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_NEURON; i++) begin
      if (!found && i > 32'(cur) && OUTPUT_MASK[i]) begin
        r     = IDX_W'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [INPUT_SIZE-1:0] lane_of(input logic [VEC_W-1:0] v,
                                                   input logic [IDX_W-1:0] i);
    return v[32'(i) * INPUT_SIZE +: INPUT_SIZE];
  endfunction

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_GUARD,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [VEC_W-1:0] result;
  logic             complete;

  assign complete = ((nn_output_valid & OUTPUT_MASK) == OUTPUT_MASK);
  assign in_ready = (state == S_LOAD);
  assign busy     = !((state == S_LOAD) && (cnt == '0));

`ifdef NN_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt;
  logic            error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Sequencer: load lanes, pulse start, mask stale valids, capture, drain selected lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      cnt       <= '0;
      idx       <= '0;
      nn_input  <= '0;
      result    <= '0;
      nn_start  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef NN_WATCHDOG_EN
      wd_cnt    <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      nn_start <= 1'b0;
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            nn_input[32'(cnt) * INPUT_SIZE +: INPUT_SIZE] <= in_data;
            if (cnt == IDX_W'(NUM_NEURON - 1)) begin
              cnt      <= '0;
              state    <= S_START;
              nn_start <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_START: begin
          state <= S_GUARD;
`ifdef NN_WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        S_GUARD: begin
          state <= S_WAIT;
`ifdef NN_WATCHDOG_EN
          wd_cnt <= wd_cnt + 1'b1;
`endif
        end
        S_WAIT: begin
          if (complete) begin
            result    <= nn_output;
            idx       <= FIRST_IDX;
            out_data  <= lane_of(nn_output, FIRST_IDX);
            out_valid <= 1'b1;
            out_last  <= (FIRST_IDX == LAST_IDX);
            state     <= S_DRAIN;
          end
`ifdef NN_WATCHDOG_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            error_q <= 1'b1;
            cnt     <= '0;
            state   <= S_LOAD;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        S_DRAIN: begin
          if (out_valid && out_ready) begin
            if (idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= S_LOAD;
            end else begin
              idx      <= next_idx(idx);
              out_data <= lane_of(result, next_idx(idx));
              out_last <= (next_idx(idx) == LAST_IDX);
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_stream_adapter.sv
// Randomised bench for nn_stream_adapter: full-mask and sparse-mask instances checked
// against an expected-beat queue built from the mask and the network result vector.
module tb_nn_stream_adapter;

  localparam int unsigned N  = 6;
  localparam int unsigned W  = 9;
  localparam int unsigned VW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data [2];
  logic          in_valid [2];
  logic          in_ready [2];
  logic          nn_start [2];
  logic [VW-1:0] nn_input [2];
  logic [VW-1:0] nn_output [2];
  logic [N-1:0]  nn_output_valid [2];
  logic [W-1:0]  out_data [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic          out_last [2];
  logic          busy [2];
  logic          error [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nn_stream_adapter #(.NUM_NEURON(N), .INPUT_SIZE(W), .OUTPUT_MASK(6'b111111), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .nn_start(nn_start[0]), .nn_input(nn_input[0]), .nn_output(nn_output[0]),
    .nn_output_valid(nn_output_valid[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_last(out_last[0]), .busy(busy[0]), .error(error[0]));

  nn_stream_adapter #(.NUM_NEURON(N), .INPUT_SIZE(W), .OUTPUT_MASK(6'b101010), .TIMEOUT_CYCLES(16)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .nn_start(nn_start[1]), .nn_input(nn_input[1]), .nn_output(nn_output[1]),
    .nn_output_valid(nn_output_valid[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_last(out_last[1]), .busy(busy[1]), .error(error[1]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] mask_of(input int sel);
    return (sel == 0) ? 6'b111111 : 6'b101010;
  endfunction

  function automatic int pick_bit(input logic [N-1:0] m);
    int b;
    do b = int'($urandom_range(0, N - 1)); while (!m[b]);
    return b;
  endfunction

  function automatic logic [VW-1:0] seq_vec(input int base);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(N); i++) v[i*W +: W] = W'(base + i);
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < int'(N); i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic check_reset_state(input int sel);
    check("rst_in_ready", 64'(in_ready[sel]), 64'd1);
    check("rst_busy", 64'(busy[sel]), 64'd0);
    check("rst_nn_start", 64'(nn_start[sel]), 64'd0);
    check("rst_out_valid", 64'(out_valid[sel]), 64'd0);
    check("rst_out_last", 64'(out_last[sel]), 64'd0);
    check("rst_error", 64'(error[sel]), 64'd0);
    check("rst_nn_input", 64'(nn_input[sel]), 64'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Feeds nbeats lanes with optional idle gaps; returns one cycle after the last accepted beat.
  task automatic load_beats(input int sel, input logic [VW-1:0] vin, input int nbeats, input bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid[sel] = 1'b0;
        in_data[sel]  = W'($urandom);
        step();
      end
      in_data[sel]  = vin[i*W +: W];
      in_valid[sel] = 1'b1;
      check("load_in_ready", 64'(in_ready[sel]), 64'd1);
      step();
      if (i < nbeats - 1) check("load_busy", 64'(busy[sel]), 64'd1);
    end
  endtask

  // One full vector; abort_beat >= 0 resets the adapter when that drain beat is presented.
  task automatic run_vec(input int sel, input logic [VW-1:0] vin, input logic [VW-1:0] vout,
                         input int delay, input bit pre_valid, input int ready_mode,
                         input int abort_beat);
    logic [W-1:0]  exp_q[$];
    logic [N-1:0]  m;
    int            k;
    int            cyc;
    int            t;
    bit            rdy;
    m = mask_of(sel);
    for (int i = 0; i < int'(N); i++) if (m[i]) exp_q.push_back(vout[i*W +: W]);

    nn_output[sel]       = pre_valid ? vout : rand_vec();
    nn_output_valid[sel] = pre_valid ? '1 : N'($urandom);
    load_beats(sel, vin, N, !pre_valid);

    // Start cycle: pulse, vector assembled, input closed; junk on the input must be ignored.
    check("start_pulse", 64'(nn_start[sel]), 64'd1);
    check("start_vector", 64'(nn_input[sel]), 64'(vin));
    check("start_in_ready", 64'(in_ready[sel]), 64'd0);
    in_valid[sel]        = 1'b1;
    in_data[sel]         = W'($urandom);
    nn_output_valid[sel] = '1;
    out_ready[sel]       = 1'($urandom);
    step();
    check("start_single", 64'(nn_start[sel]), 64'd0);
    check("guard_in_ready", 64'(in_ready[sel]), 64'd0);
    step();
    check("guard_ignores_valid", 64'(out_valid[sel]), 64'd0);

    if (!pre_valid) begin
      t = 2;
      while (t < delay) begin
        nn_output_valid[sel] = N'($urandom) & ~(N'(1) << pick_bit(m));
        nn_output[sel]       = rand_vec();
        out_ready[sel]       = 1'($urandom);
        step();
        t++;
        check("wait_no_valid", 64'(out_valid[sel]), 64'd0);
      end
      nn_output_valid[sel] = m | (($urandom_range(0, 1) == 1) ? N'($urandom) : '0);
      nn_output[sel]       = vout;
    end
    step();
    check("first_valid_latency", 64'(out_valid[sel]), 64'd1);
    nn_output[sel]       = rand_vec();
    nn_output_valid[sel] = N'($urandom);

    k = 0;
    cyc = 0;
    while (k < exp_q.size() && cyc < 200) begin
      if (abort_beat >= 0 && k == abort_beat) begin
        pulse_reset();
        check_reset_state(sel);
        return;
      end
      check("drain_valid", 64'(out_valid[sel]), 64'd1);
      check("drain_data", 64'(out_data[sel]), 64'(exp_q[k]));
      check("drain_last", 64'(out_last[sel]), 64'(k == exp_q.size() - 1));
      check("drain_in_ready", 64'(in_ready[sel]), 64'd0);
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom);
      endcase
      out_ready[sel] = rdy;
      step();
      if (rdy) k++;
      cyc++;
    end
    in_valid[sel] = 1'b0;
    if (k < exp_q.size()) check("drain_timeout", 64'(k), 64'(exp_q.size()));
    check("end_out_valid", 64'(out_valid[sel]), 64'd0);
    check("end_out_last", 64'(out_last[sel]), 64'd0);
    check("end_in_ready", 64'(in_ready[sel]), 64'd1);
    check("end_busy", 64'(busy[sel]), 64'd0);
    check("end_error", 64'(error[sel]), 64'd0);
    check("end_vector_held", 64'(nn_input[sel]), 64'(vin));
  endtask

  // Completion never arrives: watchdog aborts when enabled, otherwise the adapter keeps waiting.
  task automatic wd_test(input int sel);
    nn_output_valid[sel] = '0;
    load_beats(sel, rand_vec(), N, 1'b0);
    in_valid[sel] = 1'b0;
    step();  // first GUARD cycle
`ifdef NN_WATCHDOG_EN
    for (int t = 1; t <= 16; t++) begin
      step();
      check("wd_no_valid", 64'(out_valid[sel]), 64'd0);
      if (t < 16) check("wd_early", 64'(error[sel]), 64'd0);
    end
    check("wd_error", 64'(error[sel]), 64'd1);
    check("wd_in_ready", 64'(in_ready[sel]), 64'd1);
    step();
    check("wd_sticky", 64'(error[sel]), 64'd1);
`else
    for (int t = 1; t <= 40; t++) begin
      step();
      check("hang_no_valid", 64'(out_valid[sel]), 64'd0);
    end
    check("hang_in_ready", 64'(in_ready[sel]), 64'd0);
    check("hang_error", 64'(error[sel]), 64'd0);
`endif
    pulse_reset();
    check_reset_state(sel);
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      in_data[s] = '0;
      in_valid[s] = 1'b0;
      out_ready[s] = 1'b0;
      nn_output[s] = '0;
      nn_output_valid[s] = '0;
    end
    step();
    step();
    rst = 1'b0;
    check_reset_state(0);
    check_reset_state(1);

    // Directed: lanes 1..6 in, results 10..15 five cycles after start.
    run_vec(0, seq_vec(1), seq_vec(10), 5, 1'b0, 0, -1);
    run_vec(1, seq_vec(1), seq_vec(10), 5, 1'b0, 0, -1);
    // Valids held from before start, stalled drain.
    run_vec(0, seq_vec(1), seq_vec(10), 2, 1'b1, 1, -1);
    run_vec(1, seq_vec(1), seq_vec(10), 2, 1'b1, 1, -1);

    // Reset after three beats, then a clean run.
    load_beats(0, seq_vec(20), 3, 1'b0);
    pulse_reset();
    check_reset_state(0);
    run_vec(0, seq_vec(20), seq_vec(40), 4, 1'b0, 0, -1);

    // Reset in the middle of drain, then a clean run.
    run_vec(0, seq_vec(1), seq_vec(10), 3, 1'b0, 0, 2);
    run_vec(0, seq_vec(1), seq_vec(10), 3, 1'b0, 2, -1);
    run_vec(1, seq_vec(5), seq_vec(50), 6, 1'b0, 1, 1);
    run_vec(1, seq_vec(5), seq_vec(50), 6, 1'b0, 2, -1);

    wd_test(0);
    wd_test(1);

    for (int it = 0; it < 40; it++) begin
      run_vec(it % 2, rand_vec(), rand_vec(), int'($urandom_range(2, 9)),
              1'($urandom_range(0, 1)), 2, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
